// File: rtl/divider_pkg.sv
// Shared definitions for the iterative RISC-V M-extension divide unit:
// FSM state encoding, special-case result constants and sign helpers.
package divider_pkg;

  typedef enum logic [1:0] {DIV_IDLE, DIV_ITERATE, DIV_FIXUP} div_state_e;

  localparam logic [31:0] DIV_ZERO_QUOTIENT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT32_MIN         = 32'h8000_0000;

  // Magnitude of a two's-complement operand when signed semantics apply.
  function automatic logic [31:0] abs32(input logic signed [31:0] v, input logic en);
    return (en && v[31]) ? 32'(-v) : 32'(v);
  endfunction

  // Conditional 32-bit negate; wraps for INT32_MIN.
  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic en);
    return en ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/divider_if.sv
// Request/response bundle between the EX-stage ALU (master) and the divide unit (slave).
interface divider_if;
  logic [31:0] i_dividend;
  logic [31:0] i_divisor;
  logic        i_is_signed;
  logic        i_valid_input;
  logic [31:0] o_quotient;
  logic [31:0] o_remainder;
  logic        o_valid_output;
  logic        o_completing_next_cycle;
  logic        o_busy;

  modport master (
    output i_dividend, i_divisor, i_is_signed, i_valid_input,
    input  o_quotient, o_remainder, o_valid_output, o_completing_next_cycle, o_busy
  );

  modport slave (
    input  i_dividend, i_divisor, i_is_signed, i_valid_input,
    output o_quotient, o_remainder, o_valid_output, o_completing_next_cycle, o_busy
  );
endinterface

// File: rtl/divider_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor,
// keep the difference and emit a 1 quotient bit when no borrow occurs.
module divider_step (
  input  logic [32:0] rem_i,
  input  logic [31:0] divisor_i,
  input  logic        bit_i,
  output logic [32:0] rem_o,
  output logic        q_o
);

  logic [32:0] shifted;
  logic [32:0] trial;
  // A kept remainder is always below the divisor, so its top bit never carries information.
  logic        unused_rem_msb;

  assign unused_rem_msb = rem_i[32];

  always_comb begin
    shifted = {rem_i[31:0], bit_i};
    trial   = shifted - {1'b0, divisor_i};
    q_o     = ~trial[32];
    rem_o   = q_o ? trial : shifted;
  end

endmodule

// File: rtl/divider.sv
// Iterative DIV/DIVU/REM/REMU unit: radix-2^BITS_PER_CYCLE restoring division on
// operand magnitudes, followed by one registered sign/special-case correction cycle.
module divider
  import divider_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic     i_clk,
  input  logic     i_rst,
  divider_if.slave bus
);

  localparam int         ITERS     = 32 / BITS_PER_CYCLE;
  localparam logic [5:0] ITERS_CNT = 6'(ITERS);

  div_state_e  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] orig_q, orig_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic        dz_q, dz_d;
  logic        ovf_q, ovf_d;
  logic [31:0] quotient_q, quotient_d;
  logic [31:0] remainder_q, remainder_d;
  logic        valid_q, valid_d;
  logic        compl_q, compl_d;
  logic        busy_q, busy_d;

  logic [32:0]               rem_chain [BITS_PER_CYCLE+1];
  logic [BITS_PER_CYCLE-1:0] q_bits;

  assign rem_chain[0] = rem_q;

  // Dividend bits enter MSB first; step k consumes bit 31-k of the shifting magnitude.
  for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_step
    divider_step u_step (
      .rem_i     (rem_chain[k]),
      .divisor_i (dvs_q),
      .bit_i     (dvd_q[31-k]),
      .rem_o     (rem_chain[k+1]),
      .q_o       (q_bits[BITS_PER_CYCLE-1-k])
    );
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    orig_d      = orig_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    dz_d        = dz_q;
    ovf_d       = ovf_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    valid_d     = 1'b0;
    compl_d     = 1'b0;
    busy_d      = busy_q;

    unique case (state_q)
      DIV_IDLE: begin
        if (bus.i_valid_input) begin
          dvd_d   = abs32(bus.i_dividend, bus.i_is_signed);
          dvs_d   = abs32(bus.i_divisor, bus.i_is_signed);
          orig_d  = bus.i_dividend;
          q_neg_d = bus.i_is_signed & (bus.i_dividend[31] ^ bus.i_divisor[31]);
          r_neg_d = bus.i_is_signed & bus.i_dividend[31];
          dz_d    = (bus.i_divisor == 32'd0);
          ovf_d   = bus.i_is_signed && (bus.i_dividend == INT32_MIN) &&
                    (bus.i_divisor == 32'hFFFF_FFFF);
          rem_d   = 33'd0;
          quo_d   = 32'd0;
          cnt_d   = ITERS_CNT;
          busy_d  = 1'b1;
          state_d = DIV_ITERATE;
        end
      end

      DIV_ITERATE: begin
        rem_d = rem_chain[BITS_PER_CYCLE];
        quo_d = {quo_q[31-BITS_PER_CYCLE:0], q_bits};
        dvd_d = dvd_q << BITS_PER_CYCLE;
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          compl_d = 1'b1;
          state_d = DIV_FIXUP;
        end
      end

      DIV_FIXUP: begin
        // Special cases override the magnitude result; the loop always runs its full length.
        if (dz_q) begin
          quotient_d  = DIV_ZERO_QUOTIENT;
          remainder_d = orig_q;
        end else if (ovf_q) begin
          quotient_d  = INT32_MIN;
          remainder_d = 32'd0;
        end else begin
          quotient_d  = neg_if(quo_q, q_neg_q);
          remainder_d = neg_if(rem_q[31:0], r_neg_q);
        end
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = DIV_IDLE;
      end

      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= DIV_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      orig_q      <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      valid_q     <= 1'b0;
      compl_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      orig_q      <= orig_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      dz_q        <= dz_d;
      ovf_q       <= ovf_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      valid_q     <= valid_d;
      compl_q     <= compl_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.o_quotient              = quotient_q;
  assign bus.o_remainder             = remainder_q;
  assign bus.o_valid_output          = valid_q;
  assign bus.o_completing_next_cycle = compl_q;
  assign bus.o_busy                  = busy_q;

endmodule

// File: tb/tb_divider.sv
// Bench for the divide unit: three instances (1, 2 and 4 bits per cycle) share one stimulus
// stream and are compared every cycle against a cycle-count/arithmetic reference model.
module tb_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        is_signed;
  logic        valid_in;

  int checks   = 0;
  int failures = 0;

  logic [31:0] q_o [3];
  logic [31:0] r_o [3];
  logic        v_o [3];
  logic        c_o [3];
  logic        b_o [3];

  divider_if bus [3] ();

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign bus[g].i_dividend    = dividend;
    assign bus[g].i_divisor     = divisor;
    assign bus[g].i_is_signed   = is_signed;
    assign bus[g].i_valid_input = valid_in;
    assign q_o[g] = bus[g].o_quotient;
    assign r_o[g] = bus[g].o_remainder;
    assign v_o[g] = bus[g].o_valid_output;
    assign c_o[g] = bus[g].o_completing_next_cycle;
    assign b_o[g] = bus[g].o_busy;

    divider #(.BITS_PER_CYCLE(1 << g)) u_dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // RISC-V division semantics straight from the ISA rules.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (s) begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Reference model: a request accepted while idle produces its result ITERS+1 edges later.
  int          cd   [3];
  logic        pend [3];
  logic        vexp [3];
  logic        cexp [3];
  logic [31:0] eq   [3];
  logic [31:0] er   [3];
  logic [31:0] lq   [3];
  logic [31:0] lr   [3];
  logic        started = 1'b0;

  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      vexp[g] = 1'b0;
      cexp[g] = 1'b0;
      if (rst) begin
        pend[g] = 1'b0;
        cd[g]   = 0;
        lq[g]   = 32'd0;
        lr[g]   = 32'd0;
      end else if (pend[g]) begin
        cd[g] = cd[g] - 1;
        if (cd[g] == 1) cexp[g] = 1'b1;
        if (cd[g] == 0) begin
          pend[g] = 1'b0;
          vexp[g] = 1'b1;
          lq[g]   = eq[g];
          lr[g]   = er[g];
        end
      end else if (valid_in) begin
        pend[g] = 1'b1;
        cd[g]   = (32 >> g) + 1;
        ref_div(dividend, divisor, is_signed, eq[g], er[g]);
      end
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      for (int g = 0; g < 3; g++) begin
        check($sformatf("b%0d_valid", 1 << g), 32'(v_o[g]), 32'(vexp[g]));
        check($sformatf("b%0d_completing", 1 << g), 32'(c_o[g]), 32'(cexp[g]));
        check($sformatf("b%0d_busy", 1 << g), 32'(b_o[g]), 32'(pend[g]));
        check($sformatf("b%0d_quotient", 1 << g), q_o[g], lq[g]);
        check($sformatf("b%0d_remainder", 1 << g), r_o[g], lr[g]);
      end
    end
  end

  // Issue one divide, optionally poke a second request while busy, and check the
  // 2-bit/cycle instance's latency (17 edges after accept) plus literal results.
  task automatic do_div(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic lit, input logic [31:0] xq,
                        input logic [31:0] xr, input logic glitch);
    int          seen;
    logic [31:0] gq;
    logic [31:0] gr;
    @(negedge clk);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    valid_in  = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    seen = -1;
    gq   = 32'd0;
    gr   = 32'd0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (v_o[1] && seen < 0) begin
        seen = c;
        gq   = q_o[1];
        gr   = r_o[1];
      end
      if (glitch && c == 5) begin
        dividend  = 32'd1;
        divisor   = 32'd1;
        is_signed = ~s;
        valid_in  = 1'b1;
      end
      if (c == 6) valid_in = 1'b0;
    end
    check({name, "_latency"}, 32'(seen), 32'd17);
    if (lit) begin
      check({name, "_q"}, gq, xq);
      check({name, "_r"}, gr, xr);
    end
  endtask

  initial begin
    int vcount;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;

    rst       = 1'b1;
    valid_in  = 1'b0;
    dividend  = 32'd0;
    divisor   = 32'd0;
    is_signed = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_q", q_o[1], 32'd0);
    check("reset_r", r_o[1], 32'd0);
    check("reset_valid", 32'(v_o[1]), 32'd0);
    check("reset_busy", 32'(b_o[1]), 32'd0);
    rst = 1'b0;

    do_div("divu_100_7", 32'd100, 32'd7, 1'b0, 1'b1, 32'd14, 32'd2, 1'b0);
    do_div("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    do_div("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0);
    do_div("div_5_0", 32'd5, 32'd0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd5, 1'b0);
    do_div("divu_fff0_0", 32'hFFFF_FFF0, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 1'b0);
    do_div("div_m1_0", 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_div("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h8000_0000, 32'd0, 1'b0);
    do_div("divu_ovf_ops", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'd0, 32'h8000_0000, 1'b0);
    do_div("div_m100_m7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 1'b1, 32'd14, 32'hFFFF_FFFE, 1'b0);
    do_div("div_0_5", 32'd0, 32'd5, 1'b1, 1'b1, 32'd0, 32'd0, 1'b0);
    do_div("divu_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b0);
    do_div("busy_ignore", 32'd1000, 32'd33, 1'b0, 1'b1, 32'd30, 32'd10, 1'b1);

    // Abort a divide five edges after accept.
    @(negedge clk);
    dividend  = 32'd123456;
    divisor   = 32'd789;
    is_signed = 1'b0;
    valid_in  = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vcount = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (v_o[1]) vcount++;
    end
    check("abort_no_valid", 32'(vcount), 32'd0);
    check("abort_q", q_o[1], 32'd0);
    check("abort_r", r_o[1], 32'd0);
    check("abort_busy", 32'(b_o[1]), 32'd0);
    do_div("after_abort", 32'd123456, 32'd789, 1'b0, 1'b1, 32'd156, 32'd372, 1'b0);

    // Request held continuously: each unit re-accepts on its first idle cycle.
    @(negedge clk);
    dividend  = 32'd1000;
    divisor   = 32'd3;
    is_signed = 1'b1;
    valid_in  = 1'b1;
    repeat (80) @(negedge clk);
    valid_in = 1'b0;
    repeat (40) @(negedge clk);

    for (int i = 0; i < 150; i++) begin
      a = $urandom;
      b = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = b >> $urandom_range(0, 31);
        4: a = a >> $urandom_range(0, 31);
        default: ;
      endcase
      do_div("rand", a, b, s, 1'b0, 32'd0, 32'd0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
